// File: rtl/pu_pkg.sv
// Shared fetch-unit types: fetch FSM states and the instruction width derived from `CMDS.
`ifndef CMDS
`define CMDS 15
`endif

package pu_pkg;

  localparam int INST_W = `CMDS + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order buffer between instruction memory and the decoder.
module fetch_fifo #(
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  input  logic          flush,
  output logic [1:0]    count,
  output logic [DW-1:0] head
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      // stale words stay in mem; count=0 hides them from the decoder
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, memory handshake and a 2-deep buffer to the decoder.
// Define FETCH_DEBUG_EN to print every dequeued instruction.
//
// state  | meaning
// IDLE   | out of reset, waiting for start
// RUN    | fetching while the buffer has room
// DRAIN  | halted, waiting for the last outstanding ack to discard it
// HALTED | stopped, waiting for start
module fetch_unit
  import pu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              IW       = INST_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            halt,
  output logic            im_req,
  output logic [PC_W-1:0] im_addr,
  input  logic            im_ack,
  input  logic [IW-1:0]   im_rdata,
  output logic [IW-1:0]   inst,
  output logic [PC_W-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic            halted
);

  localparam logic [PC_W-1:0] PC_ONE = 1;

  fetch_state_e        state;
  logic [PC_W-1:0]     pc;
  logic [1:0]          count;
  logic [IW+PC_W-1:0]  head;
  logic                xfer;
  logic                deq;
  logic                halt_deq;
  logic                push;
  logic                pop;
  logic                flush;
  logic                restart;

  assign im_req     = ((state == RUN) && (count < 2'd2)) || (state == DRAIN);
  assign im_addr    = pc;
  assign xfer       = im_req && im_ack;
  assign inst_valid = (count != 2'd0);
  assign deq        = inst_valid && inst_ready;
  assign halt_deq   = deq && halt;
  assign restart    = start && ((state == IDLE) || (state == HALTED));
  assign push       = xfer && (state == RUN) && !halt_deq;
  assign pop        = deq && !halt_deq;
  assign flush      = halt_deq || restart;
  assign {inst, inst_pc} = head;

  fetch_fifo #(
    .DW (IW + PC_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({im_rdata, pc}),
    .pop   (pop),
    .flush (flush),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            pc     <= RESET_PC;
            halted <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            pc <= pc + PC_ONE;
          end
          // a request still waiting for its ack has to be drained before stopping
          if (halt_deq) begin
            if (im_req && !im_ack) begin
              state <= DRAIN;
            end else begin
              state  <= HALTED;
              halted <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (im_ack) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_DEBUG_EN
  always @(posedge clk) begin
    if (rst_n && deq) begin
      $display("fetch_unit: inst_pc=%h inst=%h halt=%b", inst_pc, inst, halt);
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have the parameter PC_W, default 8, meaning program counter and instruction-address width.
REQ-002 The block SHALL have the parameter IW, default 16, meaning instruction width; it SHALL be equal to `CMDS+1.
REQ-003 The block SHALL have the parameter RESET_PC, default 0, meaning the PC value loaded at reset and on start.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, as listed in REQ-005 and REQ-006.
REQ-005 clk  in  1  sole clock; all state is updated on the rising edge.
REQ-006 rst_n  in  1  asynchronous reset, active low.
REQ-007 start  in  1  begin fetching at RESET_PC.
REQ-008 halt  in  1  decoder h output for the instruction currently presented on inst.
REQ-009 im_req  out  1  instruction-memory request.
REQ-010 im_addr  out  PC_W  instruction-memory address.
REQ-011 im_ack  in  1  memory acknowledge; im_rdata is valid in the same cycle.
REQ-012 im_rdata  in  IW  instruction word returned by memory.
REQ-013 inst  out  IW  instruction to the decoder.
REQ-014 inst_pc  out  PC_W  address of the instruction on inst.
REQ-015 inst_valid  out  1  inst and inst_pc are valid.
REQ-016 inst_ready  in  1  decoder accepts the instruction.
REQ-017 halted  out  1  processor is stopped.

Function
REQ-018 The block SHALL implement four states: IDLE, RUN, DRAIN and HALTED.
REQ-019 In IDLE or HALTED, start=1 SHALL load pc=RESET_PC, empty the buffer, clear halted and go to RUN.
REQ-020 start SHALL be ignored in RUN and DRAIN.
REQ-021 im_addr SHALL equal pc; im_req SHALL be 1 in RUN when buffer count<2.
REQ-022 A memory transfer SHALL complete on any cycle with im_req&&im_ack; ack in the same cycle as the request is legal.
REQ-023 Once raised, im_req SHALL stay high, with im_addr stable, until im_ack; at most one request SHALL be outstanding.
REQ-024 On completion, {im_rdata, pc} SHALL be written to a 2-entry in-order buffer, and pc SHALL become pc+1 modulo 2^PC_W (wrap 2^PC_W-1 -> 0).
REQ-025 inst, inst_pc and inst_valid SHALL be driven from the buffer head; ack in cycle n SHALL give inst_valid=1 at n+1 if the buffer was empty.
REQ-026 A dequeue SHALL occur on inst_valid&&inst_ready; an enqueue and a dequeue in the same cycle SHALL keep count unchanged.
REQ-027 halt SHALL be sampled only on a dequeue.
REQ-028 On a dequeue with halt=1, the buffer SHALL be flushed, and inst_valid SHALL be 0 from the next cycle.
REQ-029 After a halt dequeue, the block SHALL go to DRAIN if a request is outstanding and not acked that cycle, else to HALTED.
REQ-030 In DRAIN, im_req SHALL stay 1 until im_ack; the returned data SHALL be discarded and pc SHALL NOT increment; the block SHALL then go to HALTED.
REQ-031 In HALTED, halted SHALL be 1 and im_req and inst_valid SHALL be 0.

Reset
REQ-032 rst_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, buffer empty, im_req=0, inst=0, inst_pc=0, inst_valid=0 and halted=0.
REQ-033 Reset during an outstanding request SHALL abandon that request; the memory tolerates a dropped im_req.

Configuration
REQ-034 With FETCH_DEBUG_EN defined, each dequeue SHALL $display inst_pc, inst and halt; without it, no display code SHALL exist; logic behaviour SHALL be identical either way.

Structure
REQ-035 The fetch-state enum (IDLE/RUN/DRAIN/HALTED) and the IW=`CMDS+1 constant SHALL reside in shared package pu_pkg.
REQ-036 The 2-entry buffer SHALL be the sub-module fetch_fifo (push, pop, flush, count, head data).

Verification
REQ-037 Reset, start, zero-latency memory holding 0x2105, 0x1001, 0x0001 at 0..2, inst_ready=1 -> inst/inst_pc 0x2105/0, 0x1001/1, 0x0001/2 on consecutive cycles; halt on 0x0001 -> halted=1 next cycle, im_req=0.
REQ-038 inst_ready=0 with zero-latency memory -> exactly two acks, then im_req=0 with pc=2; release inst_ready -> 0x2105 then 0x1001 in order, fetching resumes at address 2.
REQ-039 Memory latency 3 cycles, halt dequeued while a request is pending -> DRAIN, im_req held until ack, data discarded, then halted=1, pc unchanged.
REQ-040 PC_W=4, RESET_PC=0xE, memory always ready -> im_addr sequence 0xE, 0xF, 0x0, 0x1.
REQ-041 rst_n low mid-request -> im_req, inst_valid and halted all 0 in the same cycle; start after reset -> first im_addr=RESET_PC.
REQ-042 start pulsed in RUN -> no change to pc or buffer; start in HALTED -> fetching restarts at RESET_PC with an empty buffer.
